// File: rtl/debounce_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : debounce_scan_ctrl
// Brief    : Round-robin shared debounce engine with a one-entry event port.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_scan_ctrl #(
  parameter  int NCH   = 4,
  parameter  int CNT_W = 3,
  localparam int PW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           selected_db_clk,
  input  logic           rst_n,
  input  logic           scan_en,
  input  logic [NCH-1:0] ch_en,
  input  logic [NCH-1:0] ch_bypass,
  input  logic [NCH-1:0] sync_in,
  output logic [NCH-1:0] db_out,
  output logic [PW-1:0]  scan_ch,
  output logic           evt_valid,
  output logic [PW-1:0]  evt_ch,
  output logic           evt_level,
  input  logic           evt_ready,
  output logic           evt_overflow,
  input  logic           clr_ovf
);

  localparam logic [CNT_W-1:0] CMAX    = '1;
  localparam logic [PW-1:0]    LAST_CH = PW'(NCH - 1);

  typedef enum logic {
    EVT_EMPTY = 1'b0,
    EVT_FULL  = 1'b1
  } evt_state_t;

  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [NCH-1:0]   db_q, db_d;
  logic [PW-1:0]    scan_q, scan_d;
  evt_state_t       evt_state_q, evt_state_d;
  logic [PW-1:0]    evt_ch_q, evt_ch_d;
  logic             evt_level_q, evt_level_d;
  logic             ovf_q, ovf_d;

  logic [CNT_W-1:0] slot_cnt;
  logic             slot_db;
  logic             new_evt;
  logic             ovf_set;

  // Shared count engine: only the channel under the pointer is evaluated.
  always_comb begin
    cnt_d    = cnt_q;
    db_d     = db_q;
    scan_d   = scan_q;
    slot_cnt = cnt_q[scan_q];
    slot_db  = db_q[scan_q];
    new_evt  = 1'b0;
    if (scan_en) begin
      scan_d = (scan_q == LAST_CH) ? '0 : scan_q + 1'b1;
      if (ch_en[scan_q]) begin
        if (ch_bypass[scan_q]) begin
          slot_cnt = sync_in[scan_q] ? CMAX : '0;
          slot_db  = sync_in[scan_q];
        end else begin
          if (sync_in[scan_q] && (cnt_q[scan_q] != CMAX)) begin
            slot_cnt = cnt_q[scan_q] + 1'b1;
          end else if (!sync_in[scan_q] && (cnt_q[scan_q] != '0)) begin
            slot_cnt = cnt_q[scan_q] - 1'b1;
          end
          if (slot_cnt == CMAX) begin
            slot_db = 1'b1;
          end else if (slot_cnt == '0) begin
            slot_db = 1'b0;
          end
        end
        new_evt       = (slot_db != db_q[scan_q]);
        cnt_d[scan_q] = slot_cnt;
        db_d[scan_q]  = slot_db;
      end
    end
    // Disabled channels are cleared silently, whatever the pointer is doing.
    for (int i = 0; i < NCH; i++) begin
      if (!ch_en[i]) begin
        cnt_d[i] = '0;
        db_d[i]  = 1'b0;
      end
    end
  end

  always_comb begin
    evt_state_d = evt_state_q;
    evt_ch_d    = evt_ch_q;
    evt_level_d = evt_level_q;
    ovf_set     = 1'b0;
    case (evt_state_q)
      EVT_EMPTY: begin
        if (new_evt) begin
          evt_ch_d    = scan_q;
          evt_level_d = slot_db;
          evt_state_d = EVT_FULL;
        end
      end
      EVT_FULL: begin
        if (evt_ready) begin
          if (new_evt) begin
            evt_ch_d    = scan_q;
            evt_level_d = slot_db;
          end else begin
            evt_state_d = EVT_EMPTY;
          end
        end else if (new_evt) begin
          ovf_set = 1'b1;
        end
      end
      default: evt_state_d = EVT_EMPTY;
    endcase
    ovf_d = ovf_set | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge selected_db_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
      db_q        <= '0;
      scan_q      <= '0;
      evt_state_q <= EVT_EMPTY;
      evt_ch_q    <= '0;
      evt_level_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      db_q        <= db_d;
      scan_q      <= scan_d;
      evt_state_q <= evt_state_d;
      evt_ch_q    <= evt_ch_d;
      evt_level_q <= evt_level_d;
      ovf_q       <= ovf_d;
    end
  end

  assign db_out       = db_q;
  assign scan_ch      = scan_q;
  assign evt_valid    = (evt_state_q == EVT_FULL);
  assign evt_ch       = evt_ch_q;
  assign evt_level    = evt_level_q;
  assign evt_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_debounce_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_scan_ctrl
// Brief    : Directed + random bench for debounce_scan_ctrl with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_scan_ctrl;
  localparam int NCH   = 4;
  localparam int CNT_W = 3;
  localparam int PW    = 2;
  localparam int CMAX  = 7;

  logic           selected_db_clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           scan_en;
  logic [NCH-1:0] ch_en, ch_bypass, sync_in;
  logic [NCH-1:0] db_out;
  logic [PW-1:0]  scan_ch;
  logic           evt_valid, evt_level, evt_ready, evt_overflow, clr_ovf;
  logic [PW-1:0]  evt_ch;

  debounce_scan_ctrl #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .selected_db_clk(selected_db_clk), .rst_n(rst_n), .scan_en(scan_en),
    .ch_en(ch_en), .ch_bypass(ch_bypass), .sync_in(sync_in), .db_out(db_out),
    .scan_ch(scan_ch), .evt_valid(evt_valid), .evt_ch(evt_ch),
    .evt_level(evt_level), .evt_ready(evt_ready), .evt_overflow(evt_overflow),
    .clr_ovf(clr_ovf)
  );

  always #5 selected_db_clk = ~selected_db_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: integer counters, level array and a depth-1 event queue.
  typedef struct {int ch; bit lvl;} evt_t;
  int   m_cnt [NCH];
  bit   m_db  [NCH];
  int   m_scan;
  evt_t m_q[$];
  bit   m_ovf;

  int n_acc, acc_ch2, last_ch;
  bit last_lvl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0;
      m_db[i]  = 1'b0;
    end
    m_scan = 0;
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_edge();
    int   c, nc;
    bit   nd, newe, drop;
    evt_t e;
    newe = 1'b0;
    drop = 1'b0;
    if (scan_en) begin
      c = m_scan;
      if (ch_en[c]) begin
        if (ch_bypass[c]) begin
          nc = sync_in[c] ? CMAX : 0;
          nd = sync_in[c];
        end else begin
          nc = sync_in[c] ? m_cnt[c] + 1 : m_cnt[c] - 1;
          if (nc > CMAX) nc = CMAX;
          if (nc < 0) nc = 0;
          nd = (nc == CMAX) ? 1'b1 : (nc == 0) ? 1'b0 : m_db[c];
        end
        if (nd != m_db[c]) begin
          newe  = 1'b1;
          e.ch  = c;
          e.lvl = nd;
        end
        m_cnt[c] = nc;
        m_db[c]  = nd;
      end
      m_scan = (m_scan + 1) % NCH;
    end
    for (int i = 0; i < NCH; i++) begin
      if (!ch_en[i]) begin
        m_cnt[i] = 0;
        m_db[i]  = 1'b0;
      end
    end
    if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
    if (newe) begin
      if (m_q.size() == 0) m_q.push_back(e);
      else drop = 1'b1;
    end
    m_ovf = drop ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf);
  endtask

  task automatic compare_all();
    logic [NCH-1:0] exp_db;
    for (int i = 0; i < NCH; i++) exp_db[i] = m_db[i];
    check("db_out", db_out, exp_db);
    check("scan_ch", scan_ch, m_scan);
    check("evt_valid", evt_valid, (m_q.size() > 0));
    check("evt_overflow", evt_overflow, m_ovf);
    if (m_q.size() > 0) begin
      check("evt_ch", evt_ch, m_q[0].ch);
      check("evt_level", evt_level, m_q[0].lvl);
    end
  endtask

  task automatic step();
    if (evt_valid && evt_ready) begin
      n_acc++;
      last_ch  = evt_ch;
      last_lvl = evt_level;
      if (evt_ch == 2) acc_ch2++;
    end
    model_edge();
    @(posedge selected_db_clk);
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Async reset: outputs must clear before any clock edge arrives.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    check("rst_evt_ch", evt_ch, 0);
    check("rst_evt_level", evt_level, 0);
    @(posedge selected_db_clk);
    #1;
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise, n0;
    bit hit;
    scan_en = 1'b0; ch_en = '0; ch_bypass = '0; sync_in = '0;
    evt_ready = 1'b0; clr_ovf = 1'b0;
    n_acc = 0; acc_ch2 = 0; last_ch = 0; last_lvl = 1'b0;
    #1;
    do_reset();

    // Basic filter latency on ch0
    scan_en = 1'b1; ch_en = '1; sync_in = 4'b0001; evt_ready = 1'b1;
    rise = 0;
    for (int i = 1; i <= 28; i++) begin
      step();
      if (db_out[0] && rise == 0) rise = i;
    end
    check("rise_cycle", rise, 25);
    check("first_evt_count", n_acc, 1);
    check("first_evt_ch", last_ch, 0);
    check("first_evt_lvl", last_lvl, 1);
    check("others_low", db_out[3:1], 3'b000);

    // Glitch rejection on ch1: 6 visits high never reaches CMAX
    n0 = n_acc;
    sync_in[1] = 1'b1; run(24);
    sync_in[1] = 1'b0; run(24);
    check("glitch_db1", db_out[1], 0);
    sync_in[1] = 1'b1; run(24);
    sync_in[1] = 1'b0; run(24);
    check("glitch_db1_again", db_out[1], 0);
    check("glitch_no_evt", n_acc, n0);

    // Hysteresis on ch2
    sync_in[2] = 1'b1; run(32);
    check("hyst_settled", db_out[2], 1);
    n0 = n_acc;
    sync_in[2] = 1'b0; run(12);
    check("hyst_hold", db_out[2], 1);
    sync_in[2] = 1'b1; run(12);
    check("hyst_back", db_out[2], 1);
    check("hyst_no_evt", n_acc, n0);

    // Overflow: ch0 event held, ch3 event dropped
    sync_in[0] = 1'b0; run(32);
    evt_ready = 1'b0;
    sync_in[0] = 1'b1; run(4);
    sync_in[3] = 1'b1; run(28);
    check("ovf_valid", evt_valid, 1);
    check("ovf_ch", evt_ch, 0);
    check("ovf_lvl", evt_level, 1);
    check("ovf_flag", evt_overflow, 1);
    check("ovf_db3", db_out[3], 1);
    clr_ovf = 1'b1; evt_ready = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("ovf_cleared", evt_overflow, 0);
    check("ovf_popped", evt_valid, 0);
    check("ovf_pop_ch", last_ch, 0);

    // Simultaneous pop and load
    evt_ready = 1'b0;
    sync_in[2] = 1'b0; run(32);
    check("pl_held_ch", evt_ch, 2);
    sync_in[1] = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      evt_ready = (m_scan == 1) && (m_cnt[1] == CMAX - 1) && sync_in[1] && ch_en[1];
      hit = evt_ready;
      step();
    end
    check("pl_hit", hit, 1);
    check("pl_valid", evt_valid, 1);
    check("pl_ch", evt_ch, 1);
    check("pl_lvl", evt_level, 1);
    check("pl_no_ovf", evt_overflow, 0);

    // Disable ch0 mid-hysteresis, then bypass ch2
    evt_ready = 1'b1; run(4);
    sync_in[0] = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      hit = (m_cnt[0] == 5);
    end
    check("dis_reach5", hit, 1);
    check("dis_db_before", db_out[0], 1);
    n0 = n_acc;
    ch_en[0] = 1'b0;
    step();
    check("dis_db_after", db_out[0], 0);
    check("dis_no_valid", evt_valid, 0);
    run(4);
    check("dis_no_evt", n_acc, n0);
    ch_bypass[2] = 1'b1; acc_ch2 = 0;
    for (int t = 0; t < 4; t++) begin
      sync_in[2] = ~sync_in[2];
      run(8);
      check("byp_follow", db_out[2], sync_in[2]);
    end
    run(4);
    check("byp_evt_count", acc_ch2, 4);

    // Frozen scan
    scan_en = 1'b0; run(6);
    scan_en = 1'b1;

    // Random phase with a mid-run asynchronous reset
    ch_en = '1; ch_bypass = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 39) == 0) sync_in[i] = ~sync_in[i];
        if ($urandom_range(0, 99) == 0) ch_en[i] = ~ch_en[i];
        if ($urandom_range(0, 99) == 0) ch_bypass[i] = ~ch_bypass[i];
      end
      scan_en   = ($urandom_range(0, 9) != 0);
      evt_ready = ($urandom_range(0, 3) != 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      if (n == 1500) do_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/debounce_scan_ctrl.md
# debounce_scan_ctrl

Time-multiplexed debounce scheduler that shares one up/down-count engine across NCH already-synchronized input channels. Each clock a round-robin pointer selects one channel, updates that channel's saturating counter and debounced level, and reports level changes upstream through a single-entry valid/ready event port. It runs in the selected debounce clock domain and replaces per-pin debounce counters where many slow inputs need filtering.

## Interface
- NCH, 4: number of channels, 2..16
- CNT_W, 3: per-channel counter width; CMAX = 2^CNT_W-1
- PW, derived clog2(NCH): pointer/channel-index width
- selected_db_clk  in  1  debounce clock
- rst_n  in  1  reset, asynchronous, active-low
- scan_en  in  1  1 = pointer advances and slot updates occur; 0 = frozen
- ch_en  in  NCH  per-channel enable
- ch_bypass  in  NCH  per-channel bypass (level follows input at its slot)
- sync_in  in  NCH  synchronized raw inputs (synchronizers are external)
- db_out  out  NCH  debounced levels
- scan_ch  out  PW  channel serviced this cycle
- evt_valid  out  1  event pending
- evt_ch  out  PW  channel of pending event
- evt_level  out  1  new debounced level of pending event
- evt_ready  in  1  upstream accepts event
- evt_overflow  out  1  sticky: an event was dropped
- clr_ovf  in  1  clears evt_overflow

## Operation
- Reset: all counters 0, db_out 0, scan_ch 0, evt_valid 0, evt_ch 0, evt_level 0, evt_overflow 0.
- Scan pointer: when scan_en=1, scan_ch increments each cycle and wraps NCH-1 -> 0. When scan_en=0, scan_ch holds and no counter, level or event update occurs.
- Slot update for channel c = scan_ch, with scan_en=1, ch_en[c]=1 and ch_bypass[c]=0:
  - If sync_in[c]=1 and cnt<CMAX, cnt+1. If sync_in[c]=0 and cnt>0, cnt-1. Otherwise hold (saturate). Counters never wrap.
  - If the next count equals CMAX, db_out[c] becomes 1. If it equals 0, db_out[c] becomes 0. Otherwise db_out[c] holds (hysteresis).
- Bypass slot (ch_en[c]=1, ch_bypass[c]=1): db_out[c] becomes sync_in[c]; cnt is forced to CMAX when sync_in[c]=1, else 0. Clearing bypass therefore resumes filtering without a glitch.
- Disabled channel (ch_en[c]=0): cnt and db_out[c] are forced to 0 every cycle, independent of the pointer and scan_en. This forced clear generates no event. Re-enable restarts from 0.
- Non-serviced channels hold their state.
- Event generation: a slot update that changes db_out[c] raises a new event {c, new level}. At most one new event can occur per cycle.
- Event register (states EMPTY/FULL):
  - EMPTY + new event: load, go FULL.
  - FULL + evt_ready=1: pop. If a new event arrives in the same cycle, load it and stay FULL. Otherwise go EMPTY.
  - FULL + evt_ready=0 + new event: drop the new event, keep the old one, set evt_overflow.
- evt_ch and evt_level stay stable while evt_valid=1 and evt_ready=0. A pending event survives disabling its channel.
- evt_overflow: set has priority over clr_ovf in the same cycle. It is cleared only by clr_ovf or reset.

## Timing
- Single clock domain, all outputs registered. No combinational path from inputs to outputs.
- A slot samples sync_in[c] at the posedge where scan_ch==c. db_out[c] and evt_valid update at that same edge.
- Filter latency: with cnt=0 and steady sync_in[c]=1, db_out[c] rises at the edge ending the CMAX-th visit to c. That is 7 visits, or at most 7*NCH cycles with default parameters.
- A pulse shorter than CMAX consecutive visits never toggles db_out.
- Event acceptance occurs at the edge where evt_valid=1 and evt_ready=1. evt_valid drops at the next edge unless a new event loads in the same cycle.
- Reset deassertion: the first slot update occurs for channel 0 at the first clock edge with rst_n=1 and scan_en=1.

## Test plan
- Reset, then NCH=4, all enabled, sync_in=4'b0001 steady, evt_ready=1. Required: db_out[0] rises at the 7th ch0 visit (cycle 25 after scan start); one event {ch0, level 1}; other outputs stay 0.
- Glitch rejection: ch1 is high for 6 visits, then low. Required: no db_out[1] change and no event; counter returns to 0 after 6 more visits.
- Hysteresis: ch2 is settled high (cnt=7). Drive low for 3 visits, then high. Required: db_out[2] stays 1; cnt returns to 7; no event.
- Overflow: evt_ready=0; ch0 rises, then ch3 rises. Required: evt_valid=1 holding {0,1}; evt_overflow=1; the ch3 event is lost. Assert clr_ovf and evt_ready. Required: overflow clears and the event pops.
- Simultaneous pop and load: a FULL event with evt_ready=1 in the same cycle as a new ch1 event. Required: evt_valid stays 1 with {1,level}; no overflow.
- Disable and bypass: deassert ch_en[0] while cnt=5 and db_out=1. Required: db_out[0]=0 the next cycle, no event. Set bypass on ch2 and toggle sync_in[2]. Required: db_out[2] follows at each ch2 slot, with one event per toggle.
